// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path: address width, the x0
// constant and the result entry carried by both producers and the port-B FIFO.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_live_rd(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO for long-latency results. Push is refused when full, pop is
// ignored when empty; the head entry is always visible on pop_data.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read once the count says it
  // was written, so clearing it would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Owns the register file's write port: merges the ALU path (port A, priority)
// with buffered long-latency results (port B) and bounds FIFO starvation.
// Optional: define WB_FIFO_BYPASS_EN to let port B skip an empty FIFO.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH  = WB_DATA_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_ADDR_W-1:0]   a_rd,
  input  logic [DATAWIDTH-1:0]    a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_ADDR_W-1:0]   b_rd,
  input  logic [DATAWIDTH-1:0]    b_data,
  output logic                    write,
  output logic [REG_ADDR_W-1:0]   writeReg,
  output logic [DATAWIDTH-1:0]    writeData,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int STV_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int ENTRY_W = $bits(wb_entry_t);

  if (DATAWIDTH != WB_DATA_W) begin : g_width_check
    $error("regfile_writeback: DATAWIDTH must match regfile_pkg::WB_DATA_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("regfile_writeback: DEPTH must be a power of two >= 2");
  end

  wb_entry_t         a_entry;
  wb_entry_t         b_entry;
  wb_entry_t         head;
  wb_entry_t         out_q;
  wb_entry_t         out_d;
  logic              write_q;
  logic              write_d;
  logic [STV_W-1:0]  starve_q;
  logic [STV_W-1:0]  starve_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              force_pop;
  logic              a_win;
  logic              b_live;
  logic              bypass;
  logic              push;
  logic              pop;

  assign a_entry = '{rd: a_rd, data: a_data};
  assign b_entry = '{rd: b_rd, data: b_data};

  // The FIFO head is forced out once it has lost STARVE_MAX arbitrations.
  assign force_pop = !fifo_empty && (starve_q == STV_W'(STARVE_MAX));
  assign a_ready   = !force_pop;
  assign b_ready   = !fifo_full;

  assign a_win  = a_valid && a_ready && is_live_rd(a_rd);
  assign b_live = b_valid && b_ready && is_live_rd(b_rd);
  assign pop    = force_pop || (!a_win && !fifo_empty);

`ifdef WB_FIFO_BYPASS_EN
  assign bypass = fifo_empty && !a_win && b_live;
`else
  assign bypass = 1'b0;
`endif

  assign push = b_live && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (b_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    write_d  = 1'b0;
    out_d    = out_q;
    starve_d = starve_q;

    if (pop) begin
      write_d = 1'b1;
      out_d   = head;
    end else if (a_win) begin
      write_d = 1'b1;
      out_d   = a_entry;
    end else if (bypass) begin
      write_d = 1'b1;
      out_d   = b_entry;
    end

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (a_win && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_q  <= 1'b0;
      out_q    <= '0;
      starve_q <= '0;
    end else begin
      write_q  <= write_d;
      out_q    <= out_d;
      starve_q <= starve_d;
    end
  end

  assign write     = write_q;
  assign writeReg  = out_q.rd;
  assign writeData = out_q.data;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4, STARVE_MAX=3).
// Expected values follow WB_FIFO_BYPASS_EN when it is defined for the build.
module tb_regfile_writeback;

  logic        clk;
  logic        resetn;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        write;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_writeback #(
    .DATAWIDTH  (32),
    .DEPTH      (4),
    .STARVE_MAX (3)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .write      (write),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, ".write"}, 64'(write), 64'd1);
    check({tag, ".reg"},   64'(writeReg), 64'(rd));
    check({tag, ".data"},  64'(writeData), 64'(data));
  endtask

  initial begin
    resetn  = 1'b0;
    a_valid = 1'b1;
    a_rd    = 5'd5;
    a_data  = 32'h1111_1111;
    b_valid = 1'b0;
    b_rd    = 5'd0;
    b_data  = 32'h0;

    // Reset held with port A valid: nothing may be written.
    repeat (3) tick();
    check("rst.write", 64'(write), 64'd0);
    check("rst.reg",   64'(writeReg), 64'd0);
    check("rst.data",  64'(writeData), 64'd0);
    check("rst.count", 64'(fifo_count), 64'd0);
    #2;
    a_valid = 1'b0;
    resetn  = 1'b1;
    #1;
    check("rst.a_ready", 64'(a_ready), 64'd1);
    check("rst.b_ready", 64'(b_ready), 64'd1);
    tick();
    check("rst.idle_write", 64'(write), 64'd0);

    // Port A alone.
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    tick();
    check_wr("a.rd5", 5'd5, 32'hDEAD_BEEF);
    a_rd = 5'd0; a_data = 32'hCAFE_F00D;
    tick();
    check("a.rd0.write", 64'(write), 64'd0);
    a_valid = 1'b0;
    tick();
    check("a.idle.write", 64'(write), 64'd0);

    // Fill the FIFO while port A keeps winning with rd=7.
    a_valid = 1'b1; a_rd = 5'd7;
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 32'h700 + 32'(i);
      b_rd   = 5'(10 + i);
      b_data = 32'hB0 + 32'(i);
      tick();
      check_wr($sformatf("fill%0d", i), 5'd7, 32'h700 + 32'(i));
      check($sformatf("fill%0d.count", i), 64'(fifo_count), 64'(i + 1));
    end
    check("full.b_ready", 64'(b_ready), 64'd0);
    check("full.a_ready", 64'(a_ready), 64'd0);

    // Fifth result waits: the forced pop frees a slot but the push is refused.
    b_rd = 5'd14; b_data = 32'hB4;
    tick();
    check_wr("force.b0", 5'd10, 32'hB0);
    check("force.count", 64'(fifo_count), 64'd3);
    check("force.b_ready", 64'(b_ready), 64'd1);
    a_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      b_valid = 1'b0;
      check_wr($sformatf("drain%0d", j), 5'(10 + j), 32'hB0 + 32'(j));
      check($sformatf("drain%0d.count", j), 64'(fifo_count), (j == 1) ? 64'd3 : 64'(4 - j));
    end
    tick();
    check("drain.idle", 64'(write), 64'd0);

    // Starvation: one FIFO entry against a continuously valid port A.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h300;
    b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h2020;
    tick();
    b_valid = 1'b0;
    check_wr("stv.push", 5'd3, 32'h300);
    check("stv.push.count", 64'(fifo_count), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      a_data = 32'h300 + 32'(k);
      tick();
      check_wr($sformatf("stv.a%0d", k), 5'd3, 32'h300 + 32'(k));
      check($sformatf("stv.a%0d.a_ready", k), 64'(a_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    a_data = 32'h3FF;
    tick();
    check_wr("stv.pop", 5'd20, 32'h2020);
    check("stv.pop.count", 64'(fifo_count), 64'd0);
    check("stv.pop.a_ready", 64'(a_ready), 64'd1);
    a_data = 32'h310;
    tick();
    check_wr("stv.after", 5'd3, 32'h310);

    // x0 on port B is accepted and dropped.
    a_valid = 1'b0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
    #1;
    check("x0b.b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    check("x0b.count", 64'(fifo_count), 64'd0);
    check("x0b.write0", 64'(write), 64'd0);
    tick();
    check("x0b.write1", 64'(write), 64'd0);

    // An x0 port-A transfer does not block a pending pop.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h333;
    b_valid = 1'b1; b_rd = 5'd21; b_data = 32'h21;
    tick();
    b_valid = 1'b0;
    check("x0a.count", 64'(fifo_count), 64'd1);
    a_rd = 5'd0; a_data = 32'h999;
    tick();
    check_wr("x0a.pop", 5'd21, 32'h21);
    check("x0a.count0", 64'(fifo_count), 64'd0);
    a_valid = 1'b0;
    tick();

    // Port B with an empty FIFO and idle port A.
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h55;
    tick();
    b_valid = 1'b0;
`ifdef WB_FIFO_BYPASS_EN
    check_wr("byp.e0", 5'd9, 32'h55);
    check("byp.e0.count", 64'(fifo_count), 64'd0);
    tick();
    check("byp.e1.write", 64'(write), 64'd0);
    check("byp.e1.count", 64'(fifo_count), 64'd0);
`else
    check("byp.e0.write", 64'(write), 64'd0);
    check("byp.e0.count", 64'(fifo_count), 64'd1);
    tick();
    check_wr("byp.e1", 5'd9, 32'h55);
    check("byp.e1.count", 64'(fifo_count), 64'd0);
`endif
    tick();
    check("byp.idle", 64'(write), 64'd0);

    // Reset mid-operation discards queued entries and the pending write.
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h444;
    b_valid = 1'b1; b_rd = 5'd22; b_data = 32'h22;
    tick();
    b_rd = 5'd23; b_data = 32'h23;
    tick();
    check("mid.count", 64'(fifo_count), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("mid.rst.write", 64'(write), 64'd0);
    check("mid.rst.count", 64'(fifo_count), 64'd0);
    check("mid.rst.reg",   64'(writeReg), 64'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    #2;
    resetn = 1'b1;
    tick();
    check("mid.after.write", 64'(write), 64'd0);
    check("mid.after.count", 64'(fifo_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side companion to the 32-entry register file. Owns the file's single write port (write, writeReg, writeData).
- Merges results from two producers:
  - Port A: single-cycle ALU path, has priority.
  - Port B: long-latency unit (mul/div/load), valid/ready handshake, buffered in a small FIFO.
- Enforces the x0 rule, arbitrates between producers, and bounds starvation of the FIFO.
- Drives registered outputs straight into the register file.

Parameters:
- DATAWIDTH, 32, width of result data and writeData.
- DEPTH, 4, port-B FIFO entries; power of two, >= 2.
- STARVE_MAX, 3, consecutive cycles the non-empty FIFO may lose arbitration before port A is stalled; >= 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- a_valid  in  1  port A result valid.
- a_ready  out  1  port A accepted when a_valid & a_ready.
- a_rd  in  5  port A destination register.
- a_data  in  DATAWIDTH  port A result.
- b_valid  in  1  port B result valid.
- b_ready  out  1  port B accepted when b_valid & b_ready.
- b_rd  in  5  port B destination register.
- b_data  in  DATAWIDTH  port B result.
- write  out  1  register file write enable.
- writeReg  out  5  register file write address.
- writeData  out  DATAWIDTH  register file write data.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (resetn low, async): write=0, writeReg=0, writeData=0, FIFO empty (fifo_count=0), starve counter=0. a_ready=1 and b_ready=1 as soon as reset is released.
- Outputs write/writeReg/writeData are registered. They reflect the arbitration decision of the previous edge. write=0 in any cycle with no winner.
- **Arbitration at each edge, in priority order:**
  1. If FIFO non-empty and starve==STARVE_MAX: pop FIFO head to the outputs. a_ready is 0 combinationally this cycle.
  2. Else if a_valid and a_rd!=0: port A goes to the outputs.
  3. Else if FIFO non-empty: pop head to the outputs.
  4. Else: write=0.
- a_ready = !(fifo non-empty && starve==STARVE_MAX).
- A transfer with a_rd=0 is accepted and dropped. It produces no write and does not block a FIFO pop in the same cycle.
- **Starve counter:**
  - Increments when the FIFO is non-empty and port A wins.
  - Clears to 0 on any pop, or whenever the FIFO is empty.
  - Saturates at STARVE_MAX.
- b_ready = !full. A push is refused when full, even if a pop occurs in the same cycle.
- A B transfer with b_rd=0 is accepted and discarded (not enqueued).
- FIFO is strictly in order. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.
- **Latency:**
  - A accepted at edge N: write visible from edge N until edge N+1.
  - B enqueued at edge N: earliest pop at edge N+1, so write visible after N+1.
- Ordering between A and B results targeting the same register is the issue logic's responsibility. This block performs no hazard checks.
- Reset asserted mid-operation discards all FIFO contents and any pending output write.

Optional Feature:
- Macro WB_FIFO_BYPASS_EN.
- **Defined:** when the FIFO is empty and port A does not win (a_valid=0 or a_rd=0), an accepted B result with b_rd!=0 goes straight to the outputs at the same edge. It is not enqueued, and its latency equals port A's.
- **Undefined:** B results are always enqueued first, giving a minimum of one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5.
  - REG_ZERO=5'd0.
  - typedef wb_entry_t {rd, data}, shared by both producers and the FIFO.
- Sub-module wb_fifo (parameterised DEPTH/entry width): push/pop/full/empty/count, registered storage, no internal bypass.
- Arbitration and the starve counter stay in regfile_writeback.

Test Plan:
- **Reset:** hold resetn=0 with a_valid=1 → write=0, fifo_count=0; after release, a_ready=1 and b_ready=1.
- **Port A only:** A {rd=5, data=0xDEADBEEF} → next cycle write=1, writeReg=5, writeData=0xDEADBEEF. A {rd=0} → write=0.
- **Port B FIFO fill:**
  - Push 4 B results with A idle-blocked (A continuously valid, rd=7) → fifo_count reaches 4, b_ready=0.
  - A 5th B result is held until a slot frees.
  - Results drain in push order.
- **Starvation:** FIFO holds 1 entry, A valid every cycle with rd=3, STARVE_MAX=3 → A wins 3 cycles, then a_ready=0 for one cycle and the FIFO entry is written; the counter returns to 0.
- **x0 discard:** B {rd=0, data=0x1234} accepted → fifo_count unchanged, no write ever issued.
- **Bypass (WB_FIFO_BYPASS_EN on/off):** FIFO empty, A idle, B {rd=9, data=0x55} → write appears 1 cycle after acceptance with the macro defined, 2 cycles without; fifo_count stays 0 with the macro defined.
